cam_seq: RTL

CAM_SEQ -- requirements
Module: cam_seq

---
 rtl/cam_seq_if.sv | 31 +++
 rtl/cam_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cam_seq_if.sv
// Handshake and status bundle between the camera sequencer and its
// surroundings. The master side drives the requests and the config/frame
// status; the slave side is the sequencer itself.
interface cam_seq_if;
  logic       start;
  logic       stop;
  logic [7:0] n_frames;
  logic       cfg_done;
  logic       frame_done;
  logic       cam_pwdn;
  logic       cam_rst_n;
  logic       cfg_start;
  logic       cap_en;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] frame_cnt;
  logic [2:0] state;

  modport master (
    output start, stop, n_frames, cfg_done, frame_done,
    input  cam_pwdn, cam_rst_n, cfg_start, cap_en, busy, done, err,
           frame_cnt, state
  );

  modport slave (
    input  start, stop, n_frames, cfg_done, frame_done,
    output cam_pwdn, cam_rst_n, cfg_start, cap_en, busy, done, err,
           frame_cnt, state
  );
endinterface

// File: rtl/cam_seq.sv
// Camera bring-up and capture sequencer: power-down, hardware reset and
// settle timing, configuration launch with watchdog, then frame capture
// until a frame count is reached, stop is requested, or frames stall.
// Every output is a flop computed from the next state, so no input reaches
// an output combinationally.
module cam_seq #(
  parameter int unsigned PWDN_CYC   = 250000,
  parameter int unsigned RST_CYC    = 25000,
  parameter int unsigned SETTLE_CYC = 2500000,
  parameter int unsigned TO_CYC     = 12500000
) (
  input logic      clk,
  input logic      rst_n,
  cam_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PWDN    = 3'd1,
    S_RESET   = 3'd2,
    S_SETTLE  = 3'd3,
    S_CONFIG  = 3'd4,
    S_CAPTURE = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  // A zero-length parameter behaves as a one-cycle state.
  function automatic logic [23:0] load_val(input int unsigned p);
    if (p == 0) return 24'd0;
    return 24'(p - 1);
  endfunction

  localparam logic [23:0] LD_PWDN   = load_val(PWDN_CYC);
  localparam logic [23:0] LD_RST    = load_val(RST_CYC);
  localparam logic [23:0] LD_SETTLE = load_val(SETTLE_CYC);
  localparam logic [23:0] LD_TO     = load_val(TO_CYC);

  state_e      state_q, state_d;
  logic [23:0] tmr_q, tmr_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        cfg_first_q, cfg_first_d;
  logic        cam_pwdn_q, cam_pwdn_d;
  logic        cam_rst_n_q, cam_rst_n_d;
  logic        cfg_start_q, cfg_start_d;
  logic        cap_en_q, cap_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  frame_inc;

  // Next-state, shared timer and frame counter, plus next registered outputs.
  always_comb begin
    state_d     = state_q;
    tmr_d       = (tmr_q != 24'd0) ? tmr_q - 24'd1 : 24'd0;
    frame_cnt_d = frame_cnt_q;
    cfg_first_d = 1'b0;
    frame_inc   = (frame_cnt_q == 8'hFF) ? 8'hFF : frame_cnt_q + 8'd1;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.start) begin
          state_d     = S_PWDN;
          tmr_d       = LD_PWDN;
          frame_cnt_d = 8'd0;
        end
      end
      S_PWDN: begin
        if (tmr_q == 24'd0) begin
          state_d = S_RESET;
          tmr_d   = LD_RST;
        end
      end
      S_RESET: begin
        if (tmr_q == 24'd0) begin
          state_d = S_SETTLE;
          tmr_d   = LD_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_q == 24'd0) begin
          state_d     = S_CONFIG;
          tmr_d       = LD_TO;
          cfg_first_d = 1'b1;
        end
      end
      S_CONFIG: begin
        // cfg_done may still be stale from a previous session on the first cycle.
        if (!cfg_first_q && bus.cfg_done) begin
          state_d = S_CAPTURE;
          tmr_d   = LD_TO;
        end else if (tmr_q == 24'd0) begin
          state_d = S_ERROR;
        end
      end
      S_CAPTURE: begin
        // A frame always counts and rearms the watchdog, even if it expires now.
        if (bus.frame_done) begin
          frame_cnt_d = frame_inc;
          tmr_d       = LD_TO;
          if (bus.stop || (bus.n_frames != 8'd0 && frame_inc == bus.n_frames)) begin
            state_d = S_DONE;
            tmr_d   = 24'd0;
          end
        end else if (bus.stop) begin
          state_d = S_DONE;
        end else if (tmr_q == 24'd0) begin
          state_d = S_ERROR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cam_pwdn_d  = (state_d == S_IDLE) || (state_d == S_PWDN) || (state_d == S_ERROR);
    cam_rst_n_d = (state_d == S_SETTLE) || (state_d == S_CONFIG) ||
                  (state_d == S_CAPTURE) || (state_d == S_DONE);
    cfg_start_d = (state_d == S_SETTLE) && (tmr_d == 24'd0);
    cap_en_d    = (state_d == S_CAPTURE);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERROR);
  end

  // State, timer and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= 24'd0;
      frame_cnt_q <= 8'd0;
      cfg_first_q <= 1'b0;
      cam_pwdn_q  <= 1'b1;
      cam_rst_n_q <= 1'b0;
      cfg_start_q <= 1'b0;
      cap_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      frame_cnt_q <= frame_cnt_d;
      cfg_first_q <= cfg_first_d;
      cam_pwdn_q  <= cam_pwdn_d;
      cam_rst_n_q <= cam_rst_n_d;
      cfg_start_q <= cfg_start_d;
      cap_en_q    <= cap_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.cam_pwdn  = cam_pwdn_q;
  assign bus.cam_rst_n = cam_rst_n_q;
  assign bus.cfg_start = cfg_start_q;
  assign bus.cap_en    = cap_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
